// File: rtl/render_matrix_scheduler.sv
// render_matrix_scheduler
//   Arbitrates two matrix sources (0: host/UART loader, 1: animation engine)
//   for the renderer's 256-bit vertex-matrix bus and 4-bit matrix state.
//   The granted source streams WORDS Q1.10.5 words into a staging buffer.
//   The staged matrix is committed to mtrx_out/state_out only at the start of
//   vertical blanking, so a frame never shows a half-updated matrix.
//   Optional build macro RENDER_IDENTITY_ON_RESET_EN: mtrx_out resets to the
//   Q1.10.5 identity matrix and state_out resets to 4'h1.
module render_matrix_scheduler #(
  parameter int unsigned WORDS    = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [9:0]                v_cnt,
  input  logic [1:0]                req,
  input  logic [1:0]                wr_valid,
  input  logic [DATA_W-1:0]         wr_data0,
  input  logic [DATA_W-1:0]         wr_data1,
  input  logic [3:0]                wr_state0,
  input  logic [3:0]                wr_state1,
  output logic [1:0]                gnt,
  output logic [1:0]                wr_ready,
  output logic [WORDS*DATA_W-1:0]   mtrx_out,
  output logic [3:0]                state_out,
  output logic                      commit_pulse,
  output logic                      busy,
  output logic                      load_err
);

  localparam int unsigned MW = WORDS * DATA_W;
  localparam int unsigned CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
  localparam logic [9:0]    VBL_LINE  = 10'(V_ACTIVE);

`ifdef RENDER_IDENTITY_ON_RESET_EN
  // Column-major 4x4: word k sits at row k%4, column k/4; 1.0 in Q1.10.5 is 32.
  function automatic logic [MW-1:0] identity_mtrx();
    logic [MW-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if ((k % 4) == (k / 4))
        m[MW-1-k*DATA_W -: DATA_W] = DATA_W'(32);
    end
    return m;
  endfunction

  localparam logic [MW-1:0] RST_MTRX  = identity_mtrx();
  localparam logic [3:0]    RST_STATE = 4'h1;
`else
  localparam logic [MW-1:0] RST_MTRX  = '0;
  localparam logic [3:0]    RST_STATE = 4'h0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PEND
  } state_t;

  state_t            state;
  logic [CW-1:0]     word_cnt;
  logic [MW-1:0]     stage;
  logic [3:0]        stage_state;
  logic              rr_prio;      // requester that wins the next contention
  logic [9:0]        v_cnt_q;

  logic              vblank_start;
  logic              gsel;
  logic              pick;
  logic [DATA_W-1:0] cur_data;
  logic [3:0]        cur_state;
  logic              cur_req;
  logic              xfer;

  // Previous vertical count, used to detect the first line of blanking.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) v_cnt_q <= '0;
    else      v_cnt_q <= v_cnt;
  end

  // Grant selection, granted-source muxing and handshake decode.
  always_comb begin
    vblank_start = (v_cnt == VBL_LINE) && (v_cnt_q != VBL_LINE);
    gsel         = gnt[1];
    pick         = (req == 2'b11) ? rr_prio : req[1];
    cur_data     = gsel ? wr_data1  : wr_data0;
    cur_state    = gsel ? wr_state1 : wr_state0;
    cur_req      = gsel ? req[1]    : req[0];
    wr_ready     = (state == S_LOAD) ? gnt : 2'b00;
    xfer         = gsel ? (wr_valid[1] && wr_ready[1]) : (wr_valid[0] && wr_ready[0]);
    busy         = (state != S_IDLE);
  end

  // Arbitration / load / commit state machine with registered outputs.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      word_cnt     <= '0;
      stage        <= '0;
      stage_state  <= '0;
      rr_prio      <= 1'b0;
      gnt          <= '0;
      mtrx_out     <= RST_MTRX;
      state_out    <= RST_STATE;
      commit_pulse <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      commit_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req != 2'b00) begin
            gnt      <= pick ? 2'b10 : 2'b01;
            rr_prio  <= ~pick;
            word_cnt <= '0;
            state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          // A dropped request wins over a word offered in the same cycle.
          if (!cur_req) begin
            gnt      <= '0;
            load_err <= 1'b1;
            word_cnt <= '0;
            stage    <= '0;
            state    <= S_IDLE;
          end else if (xfer) begin
            for (int unsigned k = 0; k < WORDS; k++) begin
              if (word_cnt == CW'(k))
                stage[MW-1-k*DATA_W -: DATA_W] <= cur_data;
            end
            if (word_cnt == '0)
              stage_state <= cur_state;
            if (word_cnt == LAST_WORD) begin
              gnt      <= '0;
              word_cnt <= '0;
              state    <= S_PEND;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end

        S_PEND: begin
          if (vblank_start) begin
            mtrx_out     <= stage;
            state_out    <= stage_state;
            commit_pulse <= 1'b1;
            state        <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_render_matrix_scheduler.sv
// Self-checking bench for render_matrix_scheduler: a table of load vectors
// (requests, data, expected grant and committed corner words) plus directed
// sequences for abort, vblank collision, hold and reset mid-load.
module tb_render_matrix_scheduler;

  logic         CLK = 1'b0;
  logic         rst;
  logic [9:0]   v_cnt;
  logic [1:0]   req;
  logic [1:0]   wr_valid;
  logic [15:0]  wr_data0, wr_data1;
  logic [3:0]   wr_state0, wr_state1;
  logic [1:0]   gnt, wr_ready;
  logic [255:0] mtrx_out;
  logic [3:0]   state_out;
  logic         commit_pulse, busy, load_err;

  always #5 CLK = ~CLK;

  render_matrix_scheduler #(
    .WORDS(16),
    .DATA_W(16),
    .V_ACTIVE(480)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .v_cnt(v_cnt),
    .req(req),
    .wr_valid(wr_valid),
    .wr_data0(wr_data0),
    .wr_data1(wr_data1),
    .wr_state0(wr_state0),
    .wr_state1(wr_state1),
    .gnt(gnt),
    .wr_ready(wr_ready),
    .mtrx_out(mtrx_out),
    .state_out(state_out),
    .commit_pulse(commit_pulse),
    .busy(busy),
    .load_err(load_err)
  );

`ifdef RENDER_IDENTITY_ON_RESET_EN
  localparam logic [255:0] RST_M = {16'h0020, 64'h0, 16'h0020, 64'h0,
                                    16'h0020, 64'h0, 16'h0020};
  localparam logic [3:0]   RST_S = 4'h1;
`else
  localparam logic [255:0] RST_M = '0;
  localparam logic [3:0]   RST_S = 4'h0;
`endif

  typedef struct {
    logic [1:0]  mask;
    logic [15:0] base;
    logic [3:0]  st;
    logic [1:0]  egnt;
    logic [15:0] top;
    logic [15:0] bot;
  } vec_t;

  vec_t         tbl [6];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [255:0] cur_m;
  logic [3:0]   cur_s;
  logic [255:0] model;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [255:0] build(input logic [15:0] base);
    logic [255:0] m;
    m = '0;
    for (int k = 0; k < 16; k++) m[255-16*k -: 16] = base + 16'(k);
    return m;
  endfunction

  // Request, wait (bounded) for the grant, then stream nwords words.
  task automatic load(input logic [1:0] mask, input logic [15:0] base, input logic [3:0] st,
                      input logic [1:0] egnt, input int nwords, input bit collide);
    bit g;
    g   = egnt[1];
    req = mask;
    for (int t = 0; t < 8 && gnt == 2'b00; t++) tick();
    chk("grant", 256'(gnt), 256'(egnt));
    for (int k = 0; k < nwords; k++) begin
      wr_valid  = egnt;
      wr_data0  = g ? 16'hDEAD : base + 16'(k);
      wr_data1  = g ? base + 16'(k) : 16'hDEAD;
      wr_state0 = (!g && k == 0) ? st : 4'hE;
      wr_state1 = ( g && k == 0) ? st : 4'hE;
      if (collide && k == 14) v_cnt = 10'd479;
      if (collide && k == 15) v_cnt = 10'd480;
      tick();
    end
    if (nwords == 16) begin
      wr_valid = mask;
      chk("pend_gnt",   256'(gnt),      256'(2'b00));
      chk("pend_ready", 256'(wr_ready), 256'(2'b00));
      chk("pend_busy",  256'(busy),     256'(1'b1));
    end
  endtask

  // Sweep v_cnt across the start of blanking and observe commit behaviour.
  task automatic vblank(input bit exp_commit, input logic [1:0] next_req, input string nm);
    int         pulses;
    int         at;
    logic [1:0] rdy_seen;
    pulses   = 0;
    at       = -1;
    rdy_seen = 2'b00;
    for (int v = 470; v <= 481; v++) begin
      v_cnt = 10'(v);
      tick();
      if (commit_pulse) begin
        pulses++;
        at = v;
        chk({nm, "_gnt_at_commit"}, 256'(gnt), 256'(2'b00));
        req      = next_req;
        wr_valid = 2'b00;
      end else if (pulses == 0) begin
        rdy_seen |= wr_ready;
      end
      if (v == 479) chk({nm, "_pre_commit"}, mtrx_out, cur_m);
    end
    v_cnt = 10'd0;
    tick();
    if (exp_commit) begin
      chk({nm, "_pulses"},    256'(pulses),   256'(1));
      chk({nm, "_pulse_at"},  256'(at),       256'(480));
      chk({nm, "_pend_rdy"},  256'(rdy_seen), 256'(2'b00));
    end else begin
      chk({nm, "_no_pulse"},  256'(pulses),   256'(0));
    end
  endtask

  initial begin
    rst = 1'b0; v_cnt = '0; req = '0; wr_valid = '0;
    wr_data0 = '0; wr_data1 = '0; wr_state0 = '0; wr_state1 = '0;
    cur_m = RST_M;
    cur_s = RST_S;

    tbl[0] = '{2'b11, 16'h0001, 4'h3, 2'b01, 16'h0001, 16'h0010};
    tbl[1] = '{2'b11, 16'h0100, 4'h5, 2'b10, 16'h0100, 16'h010F};
    tbl[2] = '{2'b11, 16'h0200, 4'h7, 2'b01, 16'h0200, 16'h020F};
    tbl[3] = '{2'b10, 16'h8000, 4'hA, 2'b10, 16'h8000, 16'h800F};
    tbl[4] = '{2'b01, 16'h7FF0, 4'hC, 2'b01, 16'h7FF0, 16'h7FFF};
    tbl[5] = '{2'b11, 16'hFFF0, 4'hF, 2'b10, 16'hFFF0, 16'hFFFF};

    #12;
    chk("rst_gnt",    256'(gnt),          256'(2'b00));
    chk("rst_ready",  256'(wr_ready),     256'(2'b00));
    chk("rst_mtrx",   mtrx_out,           RST_M);
    chk("rst_state",  256'(state_out),    256'(RST_S));
    chk("rst_commit", 256'(commit_pulse), 256'(1'b0));
    chk("rst_busy",   256'(busy),         256'(1'b0));
    chk("rst_err",    256'(load_err),     256'(1'b0));
    @(posedge CLK);
    #1;
    rst = 1'b1;
    tick();

    // Table: single load plus round-robin contention sequence.
    for (int i = 0; i < 6; i++) begin
      load(tbl[i].mask, tbl[i].base, tbl[i].st, tbl[i].egnt, 16, 1'b0);
      model = build(tbl[i].base);
      vblank(1'b1, (i < 5) ? tbl[i+1].mask : 2'b00, "vec");
      cur_m = model;
      cur_s = tbl[i].st;
      chk("vec_mtrx",  mtrx_out,                 cur_m);
      chk("vec_state", 256'(state_out),          256'(cur_s));
      chk("vec_top",   256'(mtrx_out[255:240]),  256'(tbl[i].top));
      chk("vec_bot",   256'(mtrx_out[15:0]),     256'(tbl[i].bot));
    end

    // Mid-load abort by requester 1 after 7 words.
    load(2'b10, 16'h5550, 4'h9, 2'b10, 7, 1'b0);
    req = 2'b00;
    wr_valid = 2'b00;
    tick();
    chk("abort_err",    256'(load_err),     256'(1'b1));
    chk("abort_gnt",    256'(gnt),          256'(2'b00));
    chk("abort_busy",   256'(busy),         256'(1'b0));
    chk("abort_commit", 256'(commit_pulse), 256'(1'b0));
    chk("abort_mtrx",   mtrx_out,           cur_m);
    vblank(1'b0, 2'b00, "abort");
    chk("abort_mtrx_after", mtrx_out, cur_m);

    // Last word accepted on the 479->480 edge: that blanking is missed.
    load(2'b01, 16'h1230, 4'h6, 2'b01, 16, 1'b1);
    req = 2'b00;
    wr_valid = 2'b00;
    chk("collide_no_commit0", 256'(commit_pulse), 256'(1'b0));
    tick();
    chk("collide_no_commit1", 256'(commit_pulse), 256'(1'b0));
    chk("collide_mtrx_held",  mtrx_out,           cur_m);
    model = build(16'h1230);
    vblank(1'b1, 2'b00, "collide");
    cur_m = model;
    cur_s = 4'h6;
    chk("collide_mtrx",  mtrx_out,        cur_m);
    chk("collide_state", 256'(state_out), 256'(cur_s));

    // Twenty idle frames: no commit, matrix stable, error stays sticky.
    for (int f = 0; f < 20; f++) vblank(1'b0, 2'b00, "hold");
    chk("hold_mtrx",  mtrx_out,        cur_m);
    chk("hold_state", 256'(state_out), 256'(cur_s));
    chk("hold_err",   256'(load_err),  256'(1'b1));

    // Asynchronous reset in the middle of a load.
    load(2'b01, 16'h4440, 4'h2, 2'b01, 5, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_gnt",    256'(gnt),          256'(2'b00));
    chk("mid_rst_ready",  256'(wr_ready),     256'(2'b00));
    chk("mid_rst_mtrx",   mtrx_out,           RST_M);
    chk("mid_rst_state",  256'(state_out),    256'(RST_S));
    chk("mid_rst_commit", 256'(commit_pulse), 256'(1'b0));
    chk("mid_rst_busy",   256'(busy),         256'(1'b0));
    chk("mid_rst_err",    256'(load_err),     256'(1'b0));
    req = 2'b00;
    wr_valid = 2'b00;
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
